game_controller: RTL and testbench

Parametrised game-flow controller for the flappy-bird datapath: sequences ready, countdown, play, pause, post-hit grace and game-over, tracks lives, score and high score. Sits between the input conditioning (edge-detected buttons, frame tick) and the bird/pipe engines, gating them with `game_enable` and clearing them with `game_reset`. Supersedes the three-state ready/playing/done manager with multi-life play, pause and countdown.

---
 rtl/game_pkg.sv | 23 ++
 rtl/tick_counter.sv | 35 +++
 rtl/game_controller.sv | 181 ++++++++++++++++++
 tb/tb_game_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow types for the controller and the HEX/LED display logic.
package game_pkg;

   typedef enum logic [2:0] {
      GmReady     = 3'd0,
      GmCountdown = 3'd1,
      GmPlaying   = 3'd2,
      GmGrace     = 3'd3,
      GmPaused    = 3'd4,
      GmDone      = 3'd5
   } gm_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Width of the shared countdown/grace counter.
   function automatic int unsigned cnt_width(input int unsigned count_ticks,
                                             input int unsigned grace_ticks);
      return $clog2(max_u(count_ticks, grace_ticks) + 1);
   endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter stepped by the frame tick; expires on the tick that hits 1.
module tick_counter #(
   parameter int unsigned Width = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             hold_i,
   output logic             expire_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && !hold_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = tick_i & ~hold_i & (count_q == Width'(1));

endmodule

// File: rtl/game_controller.sv
// Game-flow controller: sequences ready/countdown/play/grace/pause/done and tracks
// lives, score and high score, gating the bird/pipe engines.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned LIVES       = 3,
   parameter int unsigned COUNT_TICKS = 3,
   parameter int unsigned GRACE_TICKS = 60,
   parameter int unsigned SCORE_W     = 10
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         tick_i,
   input  logic                         flap_i,
   input  logic                         pause_i,
   input  logic                         restart_i,
   input  logic                         collision_i,
   input  logic                         pipe_passed_i,
   output logic                         game_enable_o,
   output logic                         game_reset_o,
   output logic                         respawn_o,
   output logic                         invulnerable_o,
   output logic [$clog2(LIVES+1)-1:0]   lives_o,
   output logic [SCORE_W-1:0]           score_o,
   output logic [SCORE_W-1:0]           high_score_o,
   output gm_state_t                    state_o
);

   localparam int unsigned LW   = $clog2(LIVES + 1);
   localparam int unsigned CntW = cnt_width(COUNT_TICKS, GRACE_TICKS);

   localparam logic [2:0] StReady     = GmReady;
   localparam logic [2:0] StCountdown = GmCountdown;
   localparam logic [2:0] StPlaying   = GmPlaying;
   localparam logic [2:0] StGrace     = GmGrace;
   localparam logic [2:0] StPaused    = GmPaused;
   localparam logic [2:0] StDone      = GmDone;

   localparam logic [LW-1:0]      LivesInit = LW'(LIVES);
   localparam logic [SCORE_W-1:0] ScoreMax  = '1;

   logic [2:0]         state_q, state_d;
   logic [LW-1:0]      lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               game_reset_q, game_reset_d;
   logic               respawn_q, respawn_d;
   logic               game_enable_q, invulnerable_q;

   logic               cnt_load, cnt_hold, cnt_expire;
   logic [CntW-1:0]    cnt_load_val;
   logic [SCORE_W-1:0] score_sat;

   assign score_sat = (score_q == ScoreMax) ? score_q : score_q + SCORE_W'(1);
   assign cnt_hold  = !((state_q == StCountdown) || (state_q == StGrace));

   tick_counter #(
      .Width (CntW)
   ) u_tick_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .hold_i     (cnt_hold),
      .expire_o   (cnt_expire)
   );

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      score_d      = score_q;
      high_d       = high_q;
      game_reset_d = 1'b0;
      respawn_d    = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;

      case (state_q)
         StReady: begin
            if (flap_i) begin
               if (COUNT_TICKS == 0) begin
                  state_d = StPlaying;
               end else begin
                  state_d      = StCountdown;
                  cnt_load     = 1'b1;
                  cnt_load_val = CntW'(COUNT_TICKS);
               end
            end
         end
         StCountdown: begin
            if (cnt_expire) begin
               state_d = StPlaying;
            end
         end
         StPlaying: begin
            if (collision_i) begin
               if (lives_q > LW'(1)) begin
                  lives_d      = lives_q - LW'(1);
                  respawn_d    = 1'b1;
                  cnt_load     = 1'b1;
                  cnt_load_val = CntW'(GRACE_TICKS);
                  state_d      = StGrace;
               end else begin
                  // Fatal hit: any coincident pipe_passed is dropped.
                  lives_d = '0;
                  state_d = StDone;
                  if (score_q > high_q) begin
                     high_d = score_q;
                  end
               end
            end else if (pause_i) begin
               state_d = StPaused;
            end else if (pipe_passed_i) begin
               score_d = score_sat;
            end
         end
         StGrace: begin
            if (pipe_passed_i) begin
               score_d = score_sat;
            end
            if (cnt_expire) begin
               state_d = StPlaying;
            end
         end
         StPaused: begin
            if (restart_i) begin
               state_d      = StReady;
               game_reset_d = 1'b1;
               score_d      = '0;
               lives_d      = LivesInit;
            end else if (pause_i) begin
               state_d = StPlaying;
            end
         end
         StDone: begin
            if (restart_i) begin
               state_d      = StReady;
               game_reset_d = 1'b1;
               score_d      = '0;
               lives_d      = LivesInit;
            end
         end
         default: begin
            state_d = StReady;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StReady;
         lives_q        <= LivesInit;
         score_q        <= '0;
         high_q         <= '0;
         game_reset_q   <= 1'b0;
         respawn_q      <= 1'b0;
         game_enable_q  <= 1'b0;
         invulnerable_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         lives_q        <= lives_d;
         score_q        <= score_d;
         high_q         <= high_d;
         game_reset_q   <= game_reset_d;
         respawn_q      <= respawn_d;
         game_enable_q  <= (state_d == StPlaying) || (state_d == StGrace);
         invulnerable_q <= (state_d == StGrace);
      end
   end

   assign state_o        = gm_state_t'(state_q);
   assign lives_o        = lives_q;
   assign score_o        = score_q;
   assign high_score_o   = high_q;
   assign game_reset_o   = game_reset_q;
   assign respawn_o      = respawn_q;
   assign game_enable_o  = game_enable_q;
   assign invulnerable_o = invulnerable_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench: a default controller plus a 1-life, 3-bit-score, no-countdown variant.
module tb_game_controller;
   import game_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, tick, flap, pause, restart, collision, pipe_passed;

   logic       en_m, gr_m, rs_m, inv_m;
   logic [1:0] lv_m;
   logic [9:0] sc_m, hi_m;
   gm_state_t  st_m;

   logic       en_s, gr_s, rs_s, inv_s;
   logic [0:0] lv_s;
   logic [2:0] sc_s, hi_s;
   gm_state_t  st_s;

   game_controller #(
      .LIVES(3), .COUNT_TICKS(3), .GRACE_TICKS(60), .SCORE_W(10)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .flap_i(flap), .pause_i(pause),
      .restart_i(restart), .collision_i(collision), .pipe_passed_i(pipe_passed),
      .game_enable_o(en_m), .game_reset_o(gr_m), .respawn_o(rs_m), .invulnerable_o(inv_m),
      .lives_o(lv_m), .score_o(sc_m), .high_score_o(hi_m), .state_o(st_m)
   );

   game_controller #(
      .LIVES(1), .COUNT_TICKS(0), .GRACE_TICKS(2), .SCORE_W(3)
   ) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .flap_i(flap), .pause_i(pause),
      .restart_i(restart), .collision_i(collision), .pipe_passed_i(pipe_passed),
      .game_enable_o(en_s), .game_reset_o(gr_s), .respawn_o(rs_s), .invulnerable_o(inv_s),
      .lives_o(lv_s), .score_o(sc_s), .high_score_o(hi_s), .state_o(st_s)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       en, gr, rs, inv;
      logic [1:0] lv;
      logic [9:0] sc, hi;
   } snap_t;

   typedef struct packed {
      logic [2:0] st;
      logic       en, gr, rs, inv;
      logic [0:0] lv;
      logic [2:0] sc, hi;
   } snap_s_t;

   snap_t   q_m[$];
   snap_s_t q_s[$];
   snap_t   act, exp;
   snap_s_t act_s, exp_s;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic snap_t mk(gm_state_t st, logic en, logic gr, logic rs, logic inv,
                                logic [1:0] lv, logic [9:0] sc, logic [9:0] hi);
      snap_t s;
      s = {st, en, gr, rs, inv, lv, sc, hi};
      return s;
   endfunction

   function automatic snap_s_t mk_s(gm_state_t st, logic en, logic gr, logic [0:0] lv,
                                    logic [2:0] sc, logic [2:0] hi);
      snap_s_t s;
      s = {st, en, gr, 1'b0, 1'b0, lv, sc, hi};
      return s;
   endfunction

   function automatic snap_t obs_m();
      return mk(st_m, en_m, gr_m, rs_m, inv_m, lv_m, sc_m, hi_m);
   endfunction

   function automatic snap_s_t obs_s();
      snap_s_t s;
      s = {st_s, en_s, gr_s, rs_s, inv_s, lv_s, sc_s, hi_s};
      return s;
   endfunction

   task automatic drive(input logic t, input logic f, input logic p, input logic r,
                        input logic c, input logic pp);
      tick = t; flap = f; pause = p; restart = r; collision = c; pipe_passed = pp;
      @(posedge clk);
      #1;
      {tick, flap, pause, restart, collision, pipe_passed} = '0;
   endtask

   task automatic reset_dut();
      {tick, flap, pause, restart, collision, pipe_passed} = '0;
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      {tick, flap, pause, restart, collision, pipe_passed} = '0;
      rst_n = 1'b0;
      #12;
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL reset_main: got %h want %h", act, exp); end
      q_s.push_back(mk_s(GmReady, 0, 0, 1'b1, 3'd0, 3'd0));
      act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
      if (act_s !== exp_s) begin
         n_bad++; $display("FAIL reset_small: got %h want %h", act_s, exp_s);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      @(posedge clk);
      #1;
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL reset_release: got %h want %h", act, exp); end
   endtask

   task automatic test_countdown();
      // Tick coincident with flap must not count.
      q_m.push_back(mk(GmCountdown, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      drive(1, 1, 0, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL countdown_flap: got %h want %h", act, exp); end
      q_m.push_back(mk(GmCountdown, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      drive(0, 0, 1, 0, 1, 1);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL countdown_ignore: got %h want %h", act, exp); end
      for (int i = 1; i <= 3; i++) begin
         if (i < 3) q_m.push_back(mk(GmCountdown, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
         else       q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd3, 10'd0, 10'd0));
         drive(1, 0, 0, 0, 0, 0);
         act = obs_m(); exp = q_m.pop_front(); n_cmp++;
         if (act !== exp) begin
            n_bad++; $display("FAIL countdown_tick[%0d]: got %h want %h", i, act, exp);
         end
      end
   endtask

   task automatic test_score_grace();
      for (int i = 1; i <= 5; i++) begin
         q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd3, 10'(i), 10'd0));
         drive(0, 0, 0, 0, 0, 1);
         act = obs_m(); exp = q_m.pop_front(); n_cmp++;
         if (act !== exp) begin n_bad++; $display("FAIL score[%0d]: got %h want %h", i, act, exp); end
      end
      q_m.push_back(mk(GmGrace, 1, 0, 1, 1, 2'd2, 10'd5, 10'd0));
      drive(0, 0, 0, 0, 1, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL hit_respawn: got %h want %h", act, exp); end
      q_m.push_back(mk(GmGrace, 1, 0, 0, 1, 2'd2, 10'd5, 10'd0));
      drive(0, 0, 0, 0, 1, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL grace_collision: got %h want %h", act, exp); end
      q_m.push_back(mk(GmGrace, 1, 0, 0, 1, 2'd2, 10'd6, 10'd0));
      drive(0, 0, 0, 0, 0, 1);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL grace_score: got %h want %h", act, exp); end
      q_m.push_back(mk(GmGrace, 1, 0, 0, 1, 2'd2, 10'd6, 10'd0));
      drive(0, 0, 1, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL grace_pause: got %h want %h", act, exp); end
      for (int i = 1; i <= 60; i++) begin
         if (i < 60) q_m.push_back(mk(GmGrace, 1, 0, 0, 1, 2'd2, 10'd6, 10'd0));
         else        q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd2, 10'd6, 10'd0));
         drive(1, 0, 0, 0, 0, 0);
         act = obs_m(); exp = q_m.pop_front(); n_cmp++;
         if (act !== exp) begin n_bad++; $display("FAIL grace_tick[%0d]: got %h want %h", i, act, exp); end
      end
   endtask

   task automatic test_done();
      q_m.push_back(mk(GmGrace, 1, 0, 1, 1, 2'd1, 10'd6, 10'd0));
      drive(0, 0, 0, 0, 1, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL second_hit: got %h want %h", act, exp); end
      for (int i = 1; i <= 60; i++) begin
         if (i < 60) q_m.push_back(mk(GmGrace, 1, 0, 0, 1, 2'd1, 10'd6, 10'd0));
         else        q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd1, 10'd6, 10'd0));
         drive(1, 0, 0, 0, 0, 0);
         act = obs_m(); exp = q_m.pop_front(); n_cmp++;
         if (act !== exp) begin n_bad++; $display("FAIL grace2_tick[%0d]: got %h want %h", i, act, exp); end
      end
      q_m.push_back(mk(GmDone, 0, 0, 0, 0, 2'd0, 10'd6, 10'd6));
      drive(0, 0, 0, 0, 1, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL fatal_hit: got %h want %h", act, exp); end
      q_m.push_back(mk(GmDone, 0, 0, 0, 0, 2'd0, 10'd6, 10'd6));
      drive(0, 1, 1, 0, 0, 1);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL done_ignore: got %h want %h", act, exp); end
      q_m.push_back(mk(GmReady, 0, 1, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 0, 1, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL done_restart: got %h want %h", act, exp); end
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 0, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL game_reset_width: got %h want %h", act, exp); end
   endtask

   task automatic test_pause();
      q_m.push_back(mk(GmCountdown, 0, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 1, 0, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_flap: got %h want %h", act, exp); end
      for (int i = 1; i <= 3; i++) drive(1, 0, 0, 0, 0, 0);
      q_m.push_back(mk(GmPaused, 0, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 1, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_enter: got %h want %h", act, exp); end
      q_m.push_back(mk(GmPaused, 0, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(1, 0, 0, 0, 1, 1);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_frozen: got %h want %h", act, exp); end
      q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 1, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_resume: got %h want %h", act, exp); end
      q_m.push_back(mk(GmPlaying, 1, 0, 0, 0, 2'd3, 10'd1, 10'd6));
      drive(0, 0, 0, 0, 0, 1);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL resume_score: got %h want %h", act, exp); end
      q_m.push_back(mk(GmPaused, 0, 0, 0, 0, 2'd3, 10'd1, 10'd6));
      drive(0, 0, 1, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_again: got %h want %h", act, exp); end
      q_m.push_back(mk(GmReady, 0, 1, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 1, 1, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_restart: got %h want %h", act, exp); end
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd6));
      drive(0, 0, 0, 0, 0, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pause_reset_width: got %h want %h", act, exp); end
   endtask

   task automatic test_reset_mid();
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) drive(1, 0, 0, 0, 0, 0);
      q_m.push_back(mk(GmGrace, 1, 0, 1, 1, 2'd2, 10'd0, 10'd6));
      drive(0, 0, 0, 0, 1, 0);
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL mid_grace: got %h want %h", act, exp); end
      for (int i = 1; i <= 10; i++) drive(1, 0, 0, 0, 0, 0);
      // Asynchronous: sampled between clock edges.
      #2;
      rst_n = 1'b0;
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      #1;
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL mid_reset: got %h want %h", act, exp); end
      @(negedge clk);
      rst_n = 1'b1;
      q_m.push_back(mk(GmReady, 0, 0, 0, 0, 2'd3, 10'd0, 10'd0));
      @(posedge clk);
      #1;
      act = obs_m(); exp = q_m.pop_front(); n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL mid_release: got %h want %h", act, exp); end
   endtask

   task automatic test_saturate();
      reset_dut();
      q_s.push_back(mk_s(GmPlaying, 1, 0, 1'b1, 3'd0, 3'd0));
      drive(0, 1, 0, 0, 0, 0);
      act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
      if (act_s !== exp_s) begin n_bad++; $display("FAIL sat_flap: got %h want %h", act_s, exp_s); end
      for (int i = 1; i <= 9; i++) begin
         q_s.push_back(mk_s(GmPlaying, 1, 0, 1'b1, 3'((i > 7) ? 7 : i), 3'd0));
         drive(0, 0, 0, 0, 0, 1);
         act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
         if (act_s !== exp_s) begin
            n_bad++; $display("FAIL sat_score[%0d]: got %h want %h", i, act_s, exp_s);
         end
      end
      q_s.push_back(mk_s(GmDone, 0, 0, 1'b0, 3'd7, 3'd7));
      drive(0, 0, 0, 0, 1, 0);
      act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
      if (act_s !== exp_s) begin n_bad++; $display("FAIL sat_done: got %h want %h", act_s, exp_s); end
      q_s.push_back(mk_s(GmReady, 0, 1, 1'b1, 3'd0, 3'd7));
      drive(0, 0, 0, 1, 0, 0);
      act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
      if (act_s !== exp_s) begin n_bad++; $display("FAIL sat_restart: got %h want %h", act_s, exp_s); end
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      q_s.push_back(mk_s(GmDone, 0, 0, 1'b0, 3'd2, 3'd7));
      drive(0, 0, 0, 0, 1, 1);
      act_s = obs_s(); exp_s = q_s.pop_front(); n_cmp++;
      if (act_s !== exp_s) begin n_bad++; $display("FAIL fatal_drop_pass: got %h want %h", act_s, exp_s); end
   endtask

   initial begin
      {tick, flap, pause, restart, collision, pipe_passed} = '0;
      rst_n = 1'b1;
      test_reset();
      test_countdown();
      test_score_grace();
      test_done();
      test_pause();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
